// File: rtl/sbox_pkg.sv
// Shared types for the S-array initialiser: fill patterns and engine states.
package sbox_pkg;

   typedef enum logic [1:0] {
      FM_IDENT = 2'd0,
      FM_REV   = 2'd1,
      FM_CONST = 2'd2,
      FM_RSVD  = 2'd3
   } fill_mode_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_VERIFY = 2'd2,
      S_DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/sbox_init_engine_if.sv
// Control handshake plus S-memory port of the initialiser.
//   master : control FSM / RAM side (drives start, mode, fill_value, q)
//   slave  : the engine (drives the RAM address/data/enables and status)
interface sbox_init_engine_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
);
   import sbox_pkg::*;

   logic              start;
   fill_mode_e        mode;
   logic [DATA_W-1:0] fill_value;
   logic [DATA_W-1:0] q;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data;
   logic              wren;
   logic              rden;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] err_addr;

   modport master (
      output start, mode, fill_value, q,
      input  address, data, wren, rden, busy, done, err, err_addr
   );

   modport slave (
      input  start, mode, fill_value, q,
      output address, data, wren, rden, busy, done, err, err_addr
   );
endinterface

// File: rtl/sbox_pattern_gen.sv
// Combinational fill pattern f(addr, mode, fill_value), truncated to DATA_W.
//   addr       : word address
//   mode       : IDENT / REV / CONST (RSVD behaves as IDENT)
//   fill_value : constant for CONST
//   data       : pattern word
module sbox_pattern_gen
   import sbox_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
) (
   input  logic [ADDR_W-1:0] addr,
   input  fill_mode_e        mode,
   input  logic [DATA_W-1:0] fill_value,
   output logic [DATA_W-1:0] data
);

   always_comb begin
      data = DATA_W'(addr);
      case (mode)
         FM_REV:   data = DATA_W'(ADDR_W'(DEPTH - 1) - addr);
         FM_CONST: data = fill_value;
         default:  data = DATA_W'(addr);
      endcase
   end

endmodule

// File: rtl/sbox_init_engine.sv
// S-array initialiser: fills DEPTH words with a selectable pattern, one word per
// clock, on a start/done handshake; optionally reads the array back and checks it.
// Optional feature macro: SBOX_VERIFY_EN builds the read-back verify pass.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : slave modport of sbox_init_engine_if (start/mode/fill_value/q in;
//           address/data/wren/rden/busy/done/err/err_addr out)
module sbox_init_engine
   import sbox_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = $clog2(DEPTH),
   parameter int unsigned RD_LAT = 1
) (
   input logic               clk,
   input logic               reset,
   sbox_init_engine_if.slave bus
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              wren_q, wren_d;
   logic              rden_q, rden_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   fill_mode_e        mode_q, mode_d;
   logic [DATA_W-1:0] fill_q, fill_d;

   logic              start_ok_c;
   logic              last_addr_c;
   logic [ADDR_W-1:0] gen_addr_c;
   fill_mode_e        gen_mode_c;
   logic [DATA_W-1:0] gen_fill_c;
   logic [DATA_W-1:0] gen_data_c;

   assign start_ok_c  = bus.start && (state_q == S_IDLE || state_q == S_DONE);
   // Counter stops at DEPTH-1 rather than wrapping, so any DEPTH works.
   assign last_addr_c = (addr_q == ADDR_W'(DEPTH - 1));

   // Write data is computed one word ahead; at start the live inputs are used
   // because the latched copies are only loaded on that same edge.
   assign gen_addr_c = start_ok_c ? '0 : addr_q + ADDR_W'(1);
   assign gen_mode_c = start_ok_c ? bus.mode : mode_q;
   assign gen_fill_c = start_ok_c ? bus.fill_value : fill_q;

   sbox_pattern_gen #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wr_gen (
      .addr       (gen_addr_c),
      .mode       (gen_mode_c),
      .fill_value (gen_fill_c),
      .data       (gen_data_c)
   );

`ifdef SBOX_VERIFY_EN
   // Expected word and address travel with the read so they line up with q.
   logic [DATA_W-1:0] exp_data_c;
   logic              dl_vld_q  [RD_LAT];
   logic [ADDR_W-1:0] dl_addr_q [RD_LAT];
   logic [DATA_W-1:0] dl_exp_q  [RD_LAT];
   logic              chk_miss_c;
   logic              chk_last_c;

   sbox_pattern_gen #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_exp_gen (
      .addr       (addr_q),
      .mode       (mode_q),
      .fill_value (fill_q),
      .data       (exp_data_c)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            dl_vld_q[i]  <= 1'b0;
            dl_addr_q[i] <= '0;
            dl_exp_q[i]  <= '0;
         end
      end else begin
         dl_vld_q[0]  <= rden_q;
         dl_addr_q[0] <= addr_q;
         dl_exp_q[0]  <= exp_data_c;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            dl_vld_q[i]  <= dl_vld_q[i-1];
            dl_addr_q[i] <= dl_addr_q[i-1];
            dl_exp_q[i]  <= dl_exp_q[i-1];
         end
      end
   end

   assign chk_miss_c = dl_vld_q[RD_LAT-1] && (bus.q != dl_exp_q[RD_LAT-1]);
   assign chk_last_c = dl_vld_q[RD_LAT-1] && (dl_addr_q[RD_LAT-1] == ADDR_W'(DEPTH - 1));
`else
   logic unused_q_c;
   assign unused_q_c = ^bus.q;
`endif

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         wren_q     <= 1'b0;
         rden_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
         mode_q     <= FM_IDENT;
         fill_q     <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wren_q     <= wren_d;
         rden_q     <= rden_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
         mode_q     <= mode_d;
         fill_q     <= fill_d;
      end
   end

   // Next state and next registered outputs.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      wren_d     = wren_q;
      rden_d     = rden_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;
      mode_d     = mode_q;
      fill_d     = fill_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_ok_c) begin
               state_d    = S_FILL;
               addr_d     = '0;
               data_d     = gen_data_c;
               wren_d     = 1'b1;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               err_d      = 1'b0;
               err_addr_d = '0;
               mode_d     = bus.mode;
               fill_d     = bus.fill_value;
            end
         end
         S_FILL: begin
            if (last_addr_c) begin
               wren_d = 1'b0;
               addr_d = '0;
               data_d = '0;
`ifdef SBOX_VERIFY_EN
               state_d = S_VERIFY;
               rden_d  = 1'b1;
`else
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
`endif
            end else begin
               addr_d = addr_q + ADDR_W'(1);
               data_d = gen_data_c;
            end
         end
`ifdef SBOX_VERIFY_EN
         S_VERIFY: begin
            if (rden_q) begin
               if (last_addr_c) begin
                  rden_d = 1'b0;
                  addr_d = '0;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
            // err is sticky; only the first mismatch records its address.
            if (chk_miss_c) begin
               err_d = 1'b1;
               if (!err_q) err_addr_d = dl_addr_q[RD_LAT-1];
            end
            if (chk_last_c) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   assign bus.address  = addr_q;
   assign bus.data     = data_q;
   assign bus.wren     = wren_q;
   assign bus.rden     = rden_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.err_addr = err_addr_q;

endmodule

// File: tb/tb_sbox_init_engine.sv
// Bench for sbox_init_engine: two instances (DEPTH 256 / RD_LAT 2 and DEPTH 200 /
// RD_LAT 1) with behavioural RAMs, a write scoreboard and a table of fill vectors.
module tb_sbox_init_engine;
   import sbox_pkg::*;

`ifdef SBOX_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   typedef struct {
      int         inst;
      fill_mode_e mode;
      logic [7:0] fv;
      int         inj;
      logic [7:0] exp0;
      logic [7:0] exp_last;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       corrupt;
   logic       start [2];
   fill_mode_e mode  [2];
   logic [7:0] fv    [2];
   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   logic [7:0] rd_a1, rd_a2, rd_b1;

   wire [7:0] addr_w  [2];
   wire [7:0] data_w  [2];
   wire [7:0] eaddr_w [2];
   wire       wren_w  [2];
   wire       rden_w  [2];
   wire       busy_w  [2];
   wire       done_w  [2];
   wire       err_w   [2];

   wr_t  sbq [2][$];
   int   n_vec;
   int   n_miss;
   vec_t tbl [6];

   sbox_init_engine_if #(.DATA_W(8), .ADDR_W(8)) if_a ();
   sbox_init_engine_if #(.DATA_W(8), .ADDR_W(8)) if_b ();

   sbox_init_engine #(.DEPTH(256), .DATA_W(8), .RD_LAT(2)) u_a (
      .clk(clk), .reset(rst_n), .bus(if_a));
   sbox_init_engine #(.DEPTH(200), .DATA_W(8), .RD_LAT(1)) u_b (
      .clk(clk), .reset(rst_n), .bus(if_b));

   assign if_a.start = start[0];  assign if_b.start = start[1];
   assign if_a.mode  = mode[0];   assign if_b.mode  = mode[1];
   assign if_a.fill_value = fv[0]; assign if_b.fill_value = fv[1];
   assign if_a.q = rd_a2;         assign if_b.q = rd_b1;

   assign addr_w[0] = if_a.address;   assign addr_w[1] = if_b.address;
   assign data_w[0] = if_a.data;      assign data_w[1] = if_b.data;
   assign eaddr_w[0] = if_a.err_addr; assign eaddr_w[1] = if_b.err_addr;
   assign wren_w[0] = if_a.wren;      assign wren_w[1] = if_b.wren;
   assign rden_w[0] = if_a.rden;      assign rden_w[1] = if_b.rden;
   assign busy_w[0] = if_a.busy;      assign busy_w[1] = if_b.busy;
   assign done_w[0] = if_a.done;      assign done_w[1] = if_b.done;
   assign err_w[0] = if_a.err;        assign err_w[1] = if_b.err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM A: two-cycle read latency; can corrupt words 37 and 90 on write.
   always @(posedge clk) begin
      if (wren_w[0])
         mem_a[addr_w[0]] <= (corrupt && (addr_w[0] == 8'd37 || addr_w[0] == 8'd90))
                             ? (data_w[0] ^ 8'hFF) : data_w[0];
      if (rden_w[0]) rd_a1 <= mem_a[addr_w[0]];
      rd_a2 <= rd_a1;
   end

   // RAM B: one-cycle read latency.
   always @(posedge clk) begin
      if (wren_w[1]) mem_b[addr_w[1]] <= data_w[1];
      if (rden_w[1]) rd_b1 <= mem_b[addr_w[1]];
   end

   function automatic int dep_of(input int inst);
      return (inst == 0) ? 256 : 200;
   endfunction

   function automatic int exp_cycles(input int inst);
      int d;
      d = dep_of(inst);
      return d + (VER ? d + ((inst == 0) ? 2 : 1) : 0);
   endfunction

   function automatic logic [7:0] model(input fill_mode_e m, input logic [7:0] f,
                                        input int i, input int dep);
      case (m)
         FM_REV:   return 8'(dep - 1 - i);
         FM_CONST: return f;
         default:  return 8'(i);
      endcase
   endfunction

   function automatic logic [7:0] rd_mem(input int inst, input int i);
      return (inst == 0) ? mem_a[i] : mem_b[i];
   endfunction

   function automatic int bad_words(input int inst, input fill_mode_e m, input logic [7:0] f);
      int bad;
      bad = 0;
      for (int i = 0; i < dep_of(inst); i++)
         if (rd_mem(inst, i) !== model(m, f, i, dep_of(inst))) bad++;
      return bad;
   endfunction

   function automatic logic [31:0] outs(input int inst);
      return 32'({addr_w[inst], data_w[inst], wren_w[inst], rden_w[inst], busy_w[inst],
                  done_w[inst], err_w[inst], eaddr_w[inst]});
   endfunction

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Bus monitor: exclusivity, no access while idle, range, write scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            wr_t e;
            check($sformatf("wr_rd_excl%0d", i), 32'(wren_w[i] & rden_w[i]), 32'd0);
            if (!busy_w[i]) check($sformatf("idle_access%0d", i), 32'({wren_w[i], rden_w[i]}), 32'd0);
            if (wren_w[i] || rden_w[i])
               check($sformatf("addr_range%0d", i), 32'(int'(addr_w[i]) < dep_of(i)), 32'd1);
            if (wren_w[i]) begin
               if (sbq[i].size() == 0) begin
                  n_vec++;
                  n_miss++;
                  $display("FAIL sb_extra_write%0d: got write to %0h expected none", i, addr_w[i]);
               end else begin
                  e = sbq[i].pop_front();
                  check($sformatf("wr_addr%0d", i), 32'(addr_w[i]), 32'(e.addr));
                  check($sformatf("wr_data%0d", i), 32'(data_w[i]), 32'(e.data));
               end
            end
         end
      end
   end

   // Issue a start, load the scoreboard, and check the accept edge.
   task automatic kick(input int inst, input fill_mode_e m, input logic [7:0] f);
      wr_t e;
      @(negedge clk);
      start[inst] = 1'b1;
      mode[inst]  = m;
      fv[inst]    = f;
      for (int i = 0; i < dep_of(inst); i++) begin
         e.addr = 8'(i);
         e.data = model(m, f, i, dep_of(inst));
         sbq[inst].push_back(e);
      end
      @(negedge clk);
      start[inst] = 1'b0;
      check("start_ack", 32'({busy_w[inst], done_w[inst], err_w[inst]}), 32'b100);
   endtask

   // Count edges from the start edge to done; optionally pulse a stray start.
   task automatic wait_done(input int inst, input int inj, output int n);
      n = 0;
      while (!done_w[inst] && n < 2000) begin
         start[inst] = (inj >= 0 && n == inj);
         if (n == inj) begin
            mode[inst] = FM_REV;
            fv[inst]   = 8'hEE;
         end
         @(negedge clk);
         n++;
      end
      start[inst] = 1'b0;
      if (!done_w[inst]) begin
         n_vec++;
         n_miss++;
         $display("FAIL done_timeout%0d: got no done after %0d cycles", inst, n);
      end
   endtask

   initial begin
      int n;
      n_vec   = 0;
      n_miss  = 0;
      rst_n   = 1'b0;
      corrupt = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0;
         mode[i]  = FM_IDENT;
         fv[i]    = 8'h00;
      end

      tbl[0] = '{0, FM_IDENT, 8'h00, -1,  8'h00, 8'hFF};
      tbl[1] = '{0, FM_REV,   8'h00, -1,  8'hFF, 8'h00};
      tbl[2] = '{1, FM_REV,   8'h00, -1,  8'hC7, 8'h00};
      tbl[3] = '{1, FM_CONST, 8'hA5, 50,  8'hA5, 8'hA5};
      tbl[4] = '{1, FM_RSVD,  8'h33, -1,  8'h00, 8'hC7};
      tbl[5] = '{0, FM_CONST, 8'h3C, 100, 8'h3C, 8'h3C};

      #12;
      check("reset_a", outs(0), 32'd0);
      check("reset_b", outs(1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         int inst;
         inst = tbl[v].inst;
         kick(inst, tbl[v].mode, tbl[v].fv);
         wait_done(inst, tbl[v].inj, n);
         check($sformatf("done_cycles_v%0d", v), 32'(n), 32'(exp_cycles(inst)));
         check($sformatf("mem0_v%0d", v), 32'(rd_mem(inst, 0)), 32'(tbl[v].exp0));
         check($sformatf("mem_last_v%0d", v), 32'(rd_mem(inst, dep_of(inst) - 1)),
               32'(tbl[v].exp_last));
         check($sformatf("mem_all_v%0d", v), 32'(bad_words(inst, tbl[v].mode, tbl[v].fv)), 32'd0);
         check($sformatf("err_clean_v%0d", v), 32'(err_w[inst]), 32'd0);
         check($sformatf("sb_drained_v%0d", v), 32'(sbq[inst].size()), 32'd0);
         repeat (3) @(negedge clk);
         check($sformatf("done_hold_v%0d", v), 32'({done_w[inst], busy_w[inst], wren_w[inst]}), 32'b100);
      end

      // Asynchronous reset during the fill, then a clean restart.
      kick(0, FM_IDENT, 8'h00);
      repeat (100) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset", outs(0), 32'd0);
      sbq[0].delete();
      @(negedge clk);
      rst_n = 1'b1;
      kick(0, FM_CONST, 8'h77);
      wait_done(0, -1, n);
      check("restart_cycles", 32'(n), 32'(exp_cycles(0)));
      check("restart_mem", 32'(bad_words(0, FM_CONST, 8'h77)), 32'd0);
      check("restart_sb", 32'(sbq[0].size()), 32'd0);

      // Corrupted words 37 and 90: only the first is reported.
      corrupt = 1'b1;
      kick(0, FM_IDENT, 8'h00);
      wait_done(0, -1, n);
      corrupt = 1'b0;
      check("verify_cycles", 32'(n), 32'(exp_cycles(0)));
      check("verify_err", 32'(err_w[0]), 32'(VER));
      check("verify_err_addr", 32'(eaddr_w[0]), VER ? 32'd37 : 32'd0);

      // Restart from DONE with err set: err clears, new pattern lands.
      kick(0, FM_REV, 8'h00);
      wait_done(0, -1, n);
      check("b2b_cycles", 32'(n), 32'(exp_cycles(0)));
      check("b2b_mem", 32'(bad_words(0, FM_REV, 8'h00)), 32'd0);
      check("b2b_err", 32'({err_w[0], eaddr_w[0]}), 32'd0);
      check("b2b_done", 32'(done_w[0]), 32'd1);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
